force_pkt_ejector: RTL

- Receive end of the force-network packet protocol; the packetizer on the far side builds packet_t = {dest_id, force_data_t} and this block terminates it.
- Each packet arrives from the inter-node ring/link. The block compares dest_id against this node's ID.
- On a match it strips the header and queues the force_data_t payload for the local force cache.
- On a mismatch it forwards the whole packet unchanged to the next hop through a one-entry pass-through register.

---
 rtl/force_pkt_ejector.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/force_pkt_ejector.sv
// -----------------------------------------------------------------------------
// force_pkt_ejector
//
// Receive end of the force-network packet protocol. Each inbound packet_t is
// {dest_id, force_data_t}. When dest_id equals this node's ID, the header is
// stripped and the force_data_t payload is queued for the local force cache.
// Otherwise the whole packet is forwarded unchanged to the next hop through a
// one-entry pass-through register.
//
// Ports:
//   clk            single clock
//   rst_n          asynchronous active-low reset (deassertion synchronized
//                  externally)
//   my_node_id     this node's ID, static after reset
//   in_valid/in_pkt/in_ready          inbound packet handshake
//   out_valid/out_payload/out_ready   local payload (FIFO head) to force cache
//   pass_valid/pass_pkt/pass_ready    forwarded packet to next hop
//   fifo_count     current local queue occupancy (0..FIFO_DEPTH)
//   rx_local_cnt   number of local packets ejected (saturating)
//   rx_pass_cnt    number of packets forwarded (saturating)
//
// Optional feature macro: FORCE_PKT_EJECTOR_STATS_EN
//   Defined   -> 16-bit saturating rx_local_cnt / rx_pass_cnt counters.
//   Undefined -> both counter ports tied to 16'h0, no counter flops.
// -----------------------------------------------------------------------------
module force_pkt_ejector #(
   parameter int NODE_ID_WIDTH = 6,
   parameter int PKT_WIDTH     = 109,
   parameter int PAYLOAD_WIDTH = 103,
   parameter int FIFO_DEPTH    = 4
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [NODE_ID_WIDTH-1:0]       my_node_id,
   input  logic                           in_valid,
   input  logic [PKT_WIDTH-1:0]           in_pkt,
   output logic                           in_ready,
   output logic                           out_valid,
   output logic [PAYLOAD_WIDTH-1:0]       out_payload,
   input  logic                           out_ready,
   output logic                           pass_valid,
   output logic [PKT_WIDTH-1:0]           pass_pkt,
   input  logic                           pass_ready,
   output logic [$clog2(FIFO_DEPTH):0]    fifo_count,
   output logic [15:0]                    rx_local_cnt,
   output logic [15:0]                    rx_pass_cnt
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

   // Local payload queue
   logic [PAYLOAD_WIDTH-1:0] fifo_mem_q [FIFO_DEPTH];
   logic [AW-1:0]            wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]            rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]            count_q, count_d;

   // Pass-through register
   logic                     pass_valid_q, pass_valid_d;
   logic [PKT_WIDTH-1:0]     pass_pkt_q, pass_pkt_d;

   // Handshake decode
   logic fifo_full;
   logic in_fire;
   logic match;
   logic push;
   logic pass_load;
   logic pop;
   logic pass_fire;

   always_comb begin
      fifo_full = (count_q == FULL_CNT);
      // in_ready depends only on registered state and pass_ready, so there is
      // no combinational path from in_valid/in_pkt back to in_ready.
      in_ready  = !fifo_full && !(pass_valid_q && !pass_ready);
      in_fire   = in_valid && in_ready;
      match     = (in_pkt[PKT_WIDTH-1 -: NODE_ID_WIDTH] == my_node_id);
      push      = in_fire && match;
      pass_load = in_fire && !match;
      pop       = (count_q != '0) && out_ready;
      pass_fire = pass_valid_q && pass_ready;
   end

   // Next-state for queue pointers and occupancy. Pointers wrap naturally
   // because FIFO_DEPTH is a power of two.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // Next-state for the pass register. A load in the same cycle as a drain
   // keeps pass_valid high with the new packet.
   always_comb begin
      pass_valid_d = pass_valid_q;
      pass_pkt_d   = pass_pkt_q;
      if (pass_load) begin
         pass_valid_d = 1'b1;
         pass_pkt_d   = in_pkt;
      end else if (pass_fire) begin
         pass_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         pass_valid_q <= 1'b0;
         pass_pkt_q   <= '0;
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         pass_valid_q <= pass_valid_d;
         pass_pkt_q   <= pass_pkt_d;
      end
   end

   // Queue storage is deliberately left unreset; out_valid masks stale data.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem_q[wr_ptr_q] <= in_pkt[PAYLOAD_WIDTH-1:0];
      end
   end

   assign out_valid   = (count_q != '0);
   assign out_payload = fifo_mem_q[rd_ptr_q];
   assign fifo_count  = count_q;
   assign pass_valid  = pass_valid_q;
   assign pass_pkt    = pass_pkt_q;

`ifdef FORCE_PKT_EJECTOR_STATS_EN
   logic [15:0] rx_local_cnt_q, rx_local_cnt_d;
   logic [15:0] rx_pass_cnt_q,  rx_pass_cnt_d;

   // Saturating event counters
   always_comb begin
      rx_local_cnt_d = rx_local_cnt_q;
      rx_pass_cnt_d  = rx_pass_cnt_q;
      if (push && (rx_local_cnt_q != 16'hFFFF)) begin
         rx_local_cnt_d = rx_local_cnt_q + 16'd1;
      end
      if (pass_load && (rx_pass_cnt_q != 16'hFFFF)) begin
         rx_pass_cnt_d = rx_pass_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_local_cnt_q <= 16'h0;
         rx_pass_cnt_q  <= 16'h0;
      end else begin
         rx_local_cnt_q <= rx_local_cnt_d;
         rx_pass_cnt_q  <= rx_pass_cnt_d;
      end
   end

   assign rx_local_cnt = rx_local_cnt_q;
   assign rx_pass_cnt  = rx_pass_cnt_q;
`else
   assign rx_local_cnt = 16'h0;
   assign rx_pass_cnt  = 16'h0;
`endif

endmodule
